// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Shared types and constants for the manycore memory responder.
package bsg_manycore_mem_responder_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } bsg_manycore_mem_responder_state_e;

   // Data returned for store acks and out-of-range requests.
   localparam logic [31:0] RESP_ZERO_DATA = 32'h0;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_manycore_pkg.sv
// Manycore-wide types shared by endpoint-side blocks.
// Only the load-info descriptor is needed by the memory responder.
package bsg_manycore_pkg;

   typedef struct packed {
      logic       float_wb;
      logic       icache_fetch;
      logic       is_unsigned_op;
      logic       is_byte_op;
      logic       is_hex_op;
      logic [1:0] part_sel;
   } bsg_manycore_load_info_s;

endpackage

// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/response bundle between the endpoint and the memory responder.
interface bsg_manycore_mem_responder_if
   import bsg_manycore_pkg::*;
#(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 10
);
   logic                         in_v_i;
   logic                         in_we_i;
   logic [addr_width_p-1:0]      in_addr_i;
   logic [data_width_p-1:0]      in_data_i;
   logic [data_width_p/8-1:0]    in_mask_i;
   bsg_manycore_load_info_s      in_load_info_i;
   logic                         in_yumi_o;
   logic                         returning_v_o;
   logic [data_width_p-1:0]      returning_data_o;

   modport master (
      output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
      input  in_yumi_o, returning_v_o, returning_data_o
   );

   modport slave (
      input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
      output in_yumi_o, returning_v_o, returning_data_o
   );
endinterface

// File: rtl/bsg_manycore_mem_responder_sram.sv
// Single-port synchronous SRAM with per-byte write enables and 1-cycle read.
module bsg_manycore_mem_responder_sram #(
   parameter int width_p      = 32,
   parameter int els_p        = 16,
   parameter int addr_width_p = 4
) (
   input  logic                    clk_i,
   input  logic                    i_v,
   input  logic                    i_w,
   input  logic [addr_width_p-1:0] i_addr,
   input  logic [width_p-1:0]      i_data,
   input  logic [width_p/8-1:0]    i_mask,
   output logic [width_p-1:0]      o_data
);
   localparam int mask_width_lp = width_p / 8;

   logic [width_p-1:0] r_mem [els_p];
   logic [width_p-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (i_v) begin
         if (i_w) begin
            for (int b = 0; b < mask_width_lp; b++) begin
               if (i_mask[b]) r_mem[i_addr][b*8 +: 8] <= i_data[b*8 +: 8];
            end
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_data = r_rdata;

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Remote load/store target: zero-fills its SRAM after reset, then answers each request one cycle later.
// Optional per-kind request counters are enabled with BSG_MANYCORE_MEM_RESPONDER_STATS_EN.
module bsg_manycore_mem_responder
   import bsg_manycore_mem_responder_pkg::*;
#(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 10,
   parameter int els_p        = 1024
) (
   input  logic clk_i,
   input  logic reset_n_i,
   bsg_manycore_mem_responder_if.slave bus,
   output logic init_done_o,
   output logic oob_o
`ifdef BSG_MANYCORE_MEM_RESPONDER_STATS_EN
   ,
   output logic [31:0] load_count_o,
   output logic [31:0] store_count_o,
   output logic [31:0] oob_count_o
`endif
);
   localparam int lg_els_lp     = safe_clog2(els_p);
   localparam int mask_width_lp = data_width_p / 8;
   localparam logic [addr_width_p:0]  els_ext_lp  = (addr_width_p+1)'(els_p);
   localparam logic [lg_els_lp-1:0]   last_idx_lp = lg_els_lp'(els_p - 1);

   bsg_manycore_mem_responder_state_e r_state;
   logic [lg_els_lp-1:0]     r_init_cnt;
   logic                     r_init_done;
   logic                     r_oob;
   logic                     r_returning_v;
   logic                     r_rd_load;

   logic                     w_yumi;
   logic                     w_in_range;
   logic                     w_accept_ld;
   logic                     w_accept_st;
   logic                     w_accept_oob;
   logic                     w_sram_v;
   logic                     w_sram_w;
   logic [lg_els_lp-1:0]     w_sram_addr;
   logic [data_width_p-1:0]  w_sram_wdata;
   logic [mask_width_lp-1:0] w_sram_mask;
   logic [data_width_p-1:0]  w_sram_rdata;
   logic                     w_unused_load_info;

   // Load info only selects sub-word extraction, which this target never does.
   assign w_unused_load_info = ^bus.in_load_info_i;

   assign w_yumi       = (r_state == READY) & bus.in_v_i;
   assign w_in_range   = {1'b0, bus.in_addr_i} < els_ext_lp;
   assign w_accept_ld  = w_yumi &  w_in_range & ~bus.in_we_i;
   assign w_accept_st  = w_yumi &  w_in_range &  bus.in_we_i;
   assign w_accept_oob = w_yumi & ~w_in_range;

   always_comb begin
      w_sram_v     = 1'b0;
      w_sram_w     = 1'b0;
      w_sram_addr  = bus.in_addr_i[lg_els_lp-1:0];
      w_sram_wdata = bus.in_data_i;
      w_sram_mask  = bus.in_mask_i;
      if (r_state == INIT) begin
         w_sram_v     = 1'b1;
         w_sram_w     = 1'b1;
         w_sram_addr  = r_init_cnt;
         w_sram_wdata = '0;
         w_sram_mask  = '1;
      end else begin
         w_sram_v = w_accept_ld | w_accept_st;
         w_sram_w = bus.in_we_i;
      end
   end

   bsg_manycore_mem_responder_sram #(
      .width_p      (data_width_p),
      .els_p        (els_p),
      .addr_width_p (lg_els_lp)
   ) u_sram (
      .clk_i  (clk_i),
      .i_v    (w_sram_v),
      .i_w    (w_sram_w),
      .i_addr (w_sram_addr),
      .i_data (w_sram_wdata),
      .i_mask (w_sram_mask),
      .o_data (w_sram_rdata)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state       <= INIT;
         r_init_cnt    <= '0;
         r_init_done   <= 1'b0;
         r_oob         <= 1'b0;
         r_returning_v <= 1'b0;
         r_rd_load     <= 1'b0;
      end else begin
         r_returning_v <= w_yumi;
         r_rd_load     <= w_accept_ld;
         if (w_accept_oob) r_oob <= 1'b1;
         case (r_state)
            INIT: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == last_idx_lp) begin
                  r_state     <= READY;
                  r_init_done <= 1'b1;
               end
            end
            READY:   r_state <= READY;
            default: r_state <= INIT;
         endcase
      end
   end

   // Only a load response carries SRAM data; the read register is otherwise stale.
   assign bus.in_yumi_o        = w_yumi;
   assign bus.returning_v_o    = r_returning_v;
   assign bus.returning_data_o = r_rd_load ? w_sram_rdata : data_width_p'(RESP_ZERO_DATA);
   assign init_done_o          = r_init_done;
   assign oob_o                = r_oob;

`ifdef BSG_MANYCORE_MEM_RESPONDER_STATS_EN
   logic [31:0] r_load_count;
   logic [31:0] r_store_count;
   logic [31:0] r_oob_count;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_load_count  <= '0;
         r_store_count <= '0;
         r_oob_count   <= '0;
      end else begin
         if (w_accept_ld  && (r_load_count  != '1)) r_load_count  <= r_load_count  + 32'd1;
         if (w_accept_st  && (r_store_count != '1)) r_store_count <= r_store_count + 32'd1;
         if (w_accept_oob && (r_oob_count   != '1)) r_oob_count   <= r_oob_count   + 32'd1;
      end
   end

   assign load_count_o  = r_load_count;
   assign store_count_o = r_store_count;
   assign oob_count_o   = r_oob_count;
`endif

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Scoreboard bench for bsg_manycore_mem_responder with els_p=16.
module tb_bsg_manycore_mem_responder;
   import bsg_manycore_pkg::*;

   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int ELS = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bsg_manycore_mem_responder_if #(.data_width_p(DW), .addr_width_p(AW)) bus ();
   logic init_done;
   logic oob;
`ifdef BSG_MANYCORE_MEM_RESPONDER_STATS_EN
   logic [31:0] load_cnt, store_cnt, oob_cnt;
`endif

   bsg_manycore_mem_responder #(
      .data_width_p (DW),
      .addr_width_p (AW),
      .els_p        (ELS)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .bus         (bus),
      .init_done_o (init_done),
      .oob_o       (oob)
`ifdef BSG_MANYCORE_MEM_RESPONDER_STATS_EN
      ,
      .load_count_o  (load_cnt),
      .store_count_o (store_cnt),
      .oob_count_o   (oob_cnt)
`endif
   );

   int          errors = 0;
   int          checks = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] model [ELS];
   bit          mon_en = 1'b0;
   logic        pend   = 1'b0;

   // Response monitor: one pulse per yumi of the previous cycle, data from the scoreboard.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (!mon_en) begin
         pend = 1'b0;
      end else begin
         checks++;
         if (bus.returning_v_o !== pend) begin
            errors++;
            $display("FAIL resp_valid: got %b want %b", bus.returning_v_o, pend);
         end
         if (bus.returning_v_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: got data %h want no response", bus.returning_data_o);
            end else begin
               e = exp_q.pop_front();
               if (bus.returning_data_o !== e) begin
                  errors++;
                  $display("FAIL resp_data: got %h want %h", bus.returning_data_o, e);
               end else begin
                  $display("resp data=%h", bus.returning_data_o);
               end
            end
         end else begin
            checks++;
            if (bus.returning_data_o !== '0) begin
               errors++;
               $display("FAIL resp_idle_data: got %h want 0", bus.returning_data_o);
            end
         end
         pend = bus.in_yumi_o;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string tag);
      checks += 5;
      if (bus.in_yumi_o !== 1'b0)        begin errors++; $display("FAIL %s_yumi: got %b want 0", tag, bus.in_yumi_o); end
      if (bus.returning_v_o !== 1'b0)    begin errors++; $display("FAIL %s_rv: got %b want 0", tag, bus.returning_v_o); end
      if (bus.returning_data_o !== '0)   begin errors++; $display("FAIL %s_rdata: got %h want 0", tag, bus.returning_data_o); end
      if (init_done !== 1'b0)            begin errors++; $display("FAIL %s_init_done: got %b want 0", tag, init_done); end
      if (oob !== 1'b0)                  begin errors++; $display("FAIL %s_oob: got %b want 0", tag, oob); end
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [3:0] mask);
      logic [DW-1:0] e;
      @(posedge clk); #1;
      bus.in_v_i    = 1'b1;
      bus.in_we_i   = we;
      bus.in_addr_i = addr;
      bus.in_data_i = data;
      bus.in_mask_i = mask;
      e = '0;
      if (int'(addr) < ELS) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (mask[b]) model[addr][b*8 +: 8] = data[b*8 +: 8];
         end else begin
            e = model[addr];
         end
      end
      @(negedge clk);
      checks++;
      if (bus.in_yumi_o !== 1'b1) begin
         errors++;
         $display("FAIL issue_yumi: addr %0d got %b want 1", addr, bus.in_yumi_o);
      end else begin
         exp_q.push_back(e);
         $display("req we=%0d addr=%0d data=%h mask=%b expect=%h", we, addr, data, mask, e);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      bus.in_v_i = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      bus.in_v_i         = 1'b1;
      bus.in_we_i        = 1'b0;
      bus.in_addr_i      = '0;
      bus.in_data_i      = '0;
      bus.in_mask_i      = '0;
      bus.in_load_info_i = '0;
      foreach (model[i]) model[i] = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
   endtask

   // Expects reset asserted with a load of addr 0 presented; releases and times the zero-fill.
   task automatic test_init();
      @(negedge clk);
      rst_n = 1'b1;
      #1 mon_en = 1'b1;
      for (int c = 0; c < ELS; c++) begin
         if (c != 0) @(negedge clk);
         checks += 2;
         if (bus.in_yumi_o !== 1'b0) begin errors++; $display("FAIL init_yumi c%0d: got %b want 0", c, bus.in_yumi_o); end
         if (init_done !== 1'b0)     begin errors++; $display("FAIL init_done_early c%0d: got %b want 0", c, init_done); end
      end
      @(negedge clk);
      checks += 2;
      if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", init_done); end
      if (bus.in_yumi_o !== 1'b1) begin
         errors++;
         $display("FAIL first_yumi: got %b want 1", bus.in_yumi_o);
      end else begin
         exp_q.push_back(model[0]);
      end
      idle();
      drain();
   endtask

   task automatic test_load_all();
      for (int a = 0; a < ELS; a++) issue(1'b0, AW'(a), '0, '0);
      idle();
      drain();
   endtask

   task automatic test_store_load();
      issue(1'b1, 8'd3, 32'hDEADBEEF, 4'b0101);
      issue(1'b0, 8'd3, '0, '0);
      issue(1'b1, 8'd7, 32'hCAFEF00D, 4'b1111);
      issue(1'b1, 8'd7, 32'h11223344, 4'b1000);
      issue(1'b0, 8'd7, '0, '0);
      issue(1'b0, 8'd3, '0, '0);
      idle();
      drain();
   endtask

   task automatic test_oob();
      checks++;
      if (oob !== 1'b0) begin errors++; $display("FAIL oob_pre: got %b want 0", oob); end
      issue(1'b1, 8'd0, 32'h12345678, 4'b1111);
      issue(1'b1, 8'd16, 32'hFFFFFFFF, 4'b1111);
      idle();
      @(negedge clk);
      checks++;
      if (oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b want 1", oob); end
      issue(1'b0, 8'd0, '0, '0);
      issue(1'b0, 8'd200, '0, '0);
      idle();
      drain();
      checks++;
      if (oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", oob); end
   endtask

   task automatic test_reset_mid();
      int n;
      issue(1'b1, 8'd2, 32'h00000001, 4'b1111);
      issue(1'b0, 8'd2, '0, '0);
      #1 rst_n = 1'b0;
      mon_en = 1'b0;
      #1 check_reset_outputs("midreset");
      exp_q.delete();
      foreach (model[i]) model[i] = '0;
      bus.in_v_i    = 1'b1;
      bus.in_we_i   = 1'b0;
      bus.in_addr_i = '0;
      repeat (2) @(negedge clk);
      test_init();
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      issue(1'b0, 8'd2, '0, '0);
      issue(1'b0, 8'd0, '0, '0);
      idle();
      drain();
   endtask

`ifdef BSG_MANYCORE_MEM_RESPONDER_STATS_EN
   task automatic test_stats();
      logic [31:0] l0, s0, o0;
      l0 = load_cnt; s0 = store_cnt; o0 = oob_cnt;
      for (int i = 0; i < 5; i++) issue(1'b0, AW'(i), '0, '0);
      for (int i = 0; i < 3; i++) issue(1'b1, AW'(i + 8), 32'hA5A5A5A5, 4'b1111);
      issue(1'b0, 8'd40, '0, '0);
      issue(1'b1, 8'd99, 32'h1, 4'b1111);
      idle();
      drain();
      checks += 3;
      if (load_cnt - l0 !== 32'd5)  begin errors++; $display("FAIL stats_load: got %0d want 5", load_cnt - l0); end
      if (store_cnt - s0 !== 32'd3) begin errors++; $display("FAIL stats_store: got %0d want 3", store_cnt - s0); end
      if (oob_cnt - o0 !== 32'd2)   begin errors++; $display("FAIL stats_oob: got %0d want 2", oob_cnt - o0); end
   endtask
`endif

   initial begin
      test_reset();
      test_init();
      test_load_all();
      test_store_load();
      test_oob();
      test_reset_mid();
`ifdef BSG_MANYCORE_MEM_RESPONDER_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
